// File: rtl/uart_sram_transmit.sv
// Reads NUM_WORDS 16-bit words from SRAM and sends each one over UART as two 8N1 frames, high byte first.
// Defining UART_TX_PPM_HEADER_EN sends a 15-byte PPM header ahead of the SRAM data.
module uart_sram_transmit #(
  parameter int          BAUD_DIV     = 434,
  parameter logic [17:0] START_ADDR   = 18'd0,
  parameter int          NUM_WORDS    = 115200,
  parameter int          SRAM_LATENCY = 2
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int FW = $clog2(SRAM_LATENCY + 2);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  // The prefetch lands inside the start bit, so BAUD_DIV must exceed SRAM_LATENCY+1.
  localparam logic [BW-1:0] PF_CAP     = BW'(SRAM_LATENCY + 1);
  localparam logic [FW-1:0] FETCH_LAST = FW'(SRAM_LATENCY);
  localparam logic [18:0]   LAST_WORD  = 19'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_UTX_IDLE, S_UTX_FETCH, S_UTX_HIGH, S_UTX_LOW, S_UTX_DONE
`ifdef UART_TX_PPM_HEADER_EN
    , S_UTX_HDR
`endif
  } utx_state_t;

  utx_state_t     state, state_n;
  logic [15:0]    word_buf, next_buf;
  logic [18:0]    words_sent;
  logic [BW-1:0]  baud_cnt;
  logic [3:0]     bit_idx;
  logic [FW-1:0]  fetch_cnt;
  logic           serial, byte_end, first_bit, last_word, tx_bit;
  logic [7:0]     tx_byte;
  logic [2:0]     dsel;

`ifdef UART_TX_PPM_HEADER_EN
  localparam logic [119:0] HDR_STR  = "P6\n320 240\n255\n";
  localparam logic [3:0]   HDR_LAST = 4'd14;
  logic [3:0] hdr_idx;
`endif

  assign SRAM_we_n = 1'b1;
  assign byte_end  = serial && (baud_cnt == BAUD_LAST) && (bit_idx == 4'd9);
  assign first_bit = (baud_cnt == '0) && (bit_idx == 4'd0);
  assign last_word = (words_sent == LAST_WORD);
  assign dsel      = 3'(bit_idx - 4'd1);

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) state <= S_UTX_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_UTX_IDLE: if (Start) begin
`ifdef UART_TX_PPM_HEADER_EN
        state_n = S_UTX_HDR;
`else
        state_n = S_UTX_FETCH;
`endif
      end
      S_UTX_FETCH: if (fetch_cnt == FETCH_LAST) state_n = S_UTX_HIGH;
`ifdef UART_TX_PPM_HEADER_EN
      S_UTX_HDR:   if (byte_end && hdr_idx == HDR_LAST) state_n = S_UTX_HIGH;
`endif
      S_UTX_HIGH:  if (byte_end) state_n = S_UTX_LOW;
      S_UTX_LOW:   if (byte_end) state_n = last_word ? S_UTX_DONE : S_UTX_HIGH;
      S_UTX_DONE:  state_n = S_UTX_IDLE;
      default:     state_n = S_UTX_IDLE;
    endcase
  end

  always_comb begin
    serial  = 1'b0;
    tx_byte = 8'h00;
    tx_bit  = 1'b1;
    case (state)
      S_UTX_HIGH: begin serial = 1'b1; tx_byte = word_buf[15:8]; end
      S_UTX_LOW:  begin serial = 1'b1; tx_byte = word_buf[7:0];  end
`ifdef UART_TX_PPM_HEADER_EN
      S_UTX_HDR:  begin serial = 1'b1; tx_byte = HDR_STR[{HDR_LAST - hdr_idx, 3'b000} +: 8]; end
`endif
      default: ;
    endcase
    if (serial) begin
      if (bit_idx == 4'd0)      tx_bit = 1'b0;
      else if (bit_idx == 4'd9) tx_bit = 1'b1;
      else                      tx_bit = tx_byte[dsel];
    end
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      SRAM_address <= START_ADDR;
      word_buf     <= '0;
      next_buf     <= '0;
      words_sent   <= '0;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      fetch_cnt    <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      UART_TX_O    <= 1'b1;
`ifdef UART_TX_PPM_HEADER_EN
      hdr_idx      <= '0;
`endif
    end else begin
      UART_TX_O <= tx_bit;
      Done      <= (state == S_UTX_DONE);
      if (serial) begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt <= '0;
          bit_idx  <= (bit_idx == 4'd9) ? 4'd0 : bit_idx + 4'd1;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
      case (state)
        S_UTX_IDLE: if (Start) begin
          Busy         <= 1'b1;
          SRAM_address <= START_ADDR;
          words_sent   <= '0;
          fetch_cnt    <= '0;
          baud_cnt     <= '0;
          bit_idx      <= '0;
`ifdef UART_TX_PPM_HEADER_EN
          hdr_idx      <= '0;
`endif
        end
        S_UTX_FETCH: begin
          fetch_cnt <= fetch_cnt + 1'b1;
          if (fetch_cnt == FETCH_LAST) word_buf <= SRAM_read_data;
        end
`ifdef UART_TX_PPM_HEADER_EN
        // The first word is fetched under the last header byte so the data follows with no gap.
        S_UTX_HDR: begin
          if (hdr_idx == HDR_LAST && first_bit) SRAM_address <= START_ADDR;
          if (byte_end) begin
            hdr_idx <= hdr_idx + 4'd1;
            if (hdr_idx == HDR_LAST) word_buf <= SRAM_read_data;
          end
        end
`endif
        S_UTX_HIGH: begin
          if (first_bit && !last_word) SRAM_address <= SRAM_address + 18'd1;
          if (bit_idx == 4'd0 && baud_cnt == PF_CAP) next_buf <= SRAM_read_data;
        end
        S_UTX_LOW: if (byte_end && !last_word) begin
          word_buf   <= next_buf;
          words_sent <= words_sent + 19'd1;
        end
        S_UTX_DONE: Busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_sram_transmit.sv
// Directed bench for uart_sram_transmit: two instances (3 words wrapping at 2^18, single word),
// each beside a 2-cycle-latency SRAM model; the line is checked cycle by cycle.
module tb_uart_sram_transmit;
  localparam int BD = 6;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [17:0] addr_a, addr_b;
  logic [15:0] rd_a, rd_b, d1_a, d1_b;
  logic        we_a, we_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic        tx, busy, done;
  logic [17:0] addr;
  int          sel = 0;
  int          total = 0, bad = 0;
  int          exp_lat;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  uart_sram_transmit #(.BAUD_DIV(BD), .START_ADDR(18'h3FFFE), .NUM_WORDS(3), .SRAM_LATENCY(2)) u_a (
    .Clock_50(clk), .Reset(rst), .Start(start_a), .SRAM_address(addr_a), .SRAM_read_data(rd_a),
    .SRAM_we_n(we_a), .UART_TX_O(tx_a), .Busy(busy_a), .Done(done_a));
  uart_sram_transmit #(.BAUD_DIV(BD), .START_ADDR(18'h00010), .NUM_WORDS(1), .SRAM_LATENCY(2)) u_b (
    .Clock_50(clk), .Reset(rst), .Start(start_b), .SRAM_address(addr_b), .SRAM_read_data(rd_b),
    .SRAM_we_n(we_b), .UART_TX_O(tx_b), .Busy(busy_b), .Done(done_b));

  function automatic logic [15:0] sram_val(input logic [17:0] a);
    case (a)
      18'h3FFFE: return 16'h0102;
      18'h3FFFF: return 16'h0304;
      18'h00000: return 16'h0506;
      18'h00010: return 16'hA55A;
      default:   return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk) begin
    d1_a <= sram_val(addr_a); rd_a <= d1_a;
    d1_b <= sram_val(addr_b); rd_b <= d1_b;
  end

  always_comb begin
    tx   = (sel != 0) ? tx_b   : tx_a;
    busy = (sel != 0) ? busy_b : busy_a;
    done = (sel != 0) ? done_b : done_a;
    addr = (sel != 0) ? addr_b : addr_a;
  end

  task automatic set_start(input logic v);
    if (sel != 0) start_b = v; else start_a = v;
  endtask

  task automatic load_words(input int n, input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    logic [15:0]  w[3];
    logic [119:0] hdr;
    w[0] = w0; w[1] = w1; w[2] = w2;
    exp_q.delete();
`ifdef UART_TX_PPM_HEADER_EN
    hdr = "P6\n320 240\n255\n";
    for (int h = 0; h < 15; h++) exp_q.push_back(hdr[8*(14-h) +: 8]);
    exp_lat = 1;
`else
    hdr = '0;
    exp_lat = 4;
`endif
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(w[i][15:8]);
      exp_q.push_back(w[i][7:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (tx_a !== 1'b1 || tx_b !== 1'b1) begin bad++; $display("FAIL reset_tx got %b%b want 11", tx_a, tx_b); end
    total++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy got %b%b want 00", busy_a, busy_b); end
    total++; if (done_a !== 1'b0 || done_b !== 1'b0) begin bad++; $display("FAIL reset_done got %b%b want 00", done_a, done_b); end
    total++; if (we_a !== 1'b1 || we_b !== 1'b1) begin bad++; $display("FAIL reset_we_n got %b%b want 11", we_a, we_b); end
    total++; if (addr_a !== 18'h3FFFE) begin bad++; $display("FAIL reset_addr_a got %h want 3fffe", addr_a); end
    total++; if (addr_b !== 18'h00010) begin bad++; $display("FAIL reset_addr_b got %h want 00010", addr_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // post: 0 nothing, 1 Start during DONE (must be ignored), 2 Start in the idle cycle right after DONE.
  task automatic run_stream(input int sel_i, input int again_at, input int post,
                            input logic [17:0] exp_addr, input string tag);
    int nb, cnt, err, side_err, idx;
    logic [7:0] got, eb;
    logic ebit;
    sel = sel_i;
    nb  = exp_q.size();
    side_err = 0;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got %b want 1", tag, busy); end
    cnt = 1;
    while (tx !== 1'b0 && cnt < 60) begin @(negedge clk); cnt++; end
    total++; if (cnt - 1 != exp_lat) begin bad++; $display("FAIL %s latency got %0d want %0d", tag, cnt - 1, exp_lat); end
    for (int b = 0; b < nb; b++) begin
      err = 0; got = 8'h00; eb = exp_q[b];
      for (int j = 0; j < 10; j++) begin
        for (int k = 0; k < BD; k++) begin
          idx = b*10*BD + j*BD + k;
          if (idx > 0) @(negedge clk);
          ebit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : eb[j-1];
          if (tx !== ebit) err++;
          if (k == BD/2 && j >= 1 && j <= 8) got[j-1] = tx;
          if (busy !== 1'b1 || done !== 1'b0) side_err++;
          set_start(idx == again_at);
        end
      end
      total++; if (got !== eb) begin bad++; $display("FAIL %s byte%0d got %h want %h", tag, b, got, eb); end
      total++; if (err != 0) begin bad++; $display("FAIL %s frame%0d bad_cycles got %0d want 0", tag, b, err); end
    end
    total++; if (side_err != 0) begin bad++; $display("FAIL %s busy_done_during_stream got %0d want 0", tag, side_err); end
    if (post == 1) set_start(1'b1);
    @(negedge clk);
    set_start(post == 2);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL %s done_pulse got %b want 1", tag, done); end
    total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL %s end_busy_tx got %b%b want 01", tag, busy, tx); end
    @(negedge clk);
    set_start(1'b0);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s done_width got %b want 0", tag, done); end
    if (post == 1) begin
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s start_in_done got busy %b want 0", tag, busy); end
    end
    if (post == 2) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s back_to_back got busy %b want 1", tag, busy); end
      cnt = 1;
      while (done !== 1'b1 && cnt < 5000) begin @(negedge clk); cnt++; end
      total++;
      if (cnt != exp_lat + 1 + 10*BD*nb) begin
        bad++; $display("FAIL %s back_to_back_done got %0d want %0d", tag, cnt, exp_lat + 1 + 10*BD*nb);
      end
      @(negedge clk);
    end
    total++; if (addr !== exp_addr) begin bad++; $display("FAIL %s final_addr got %h want %h", tag, addr, exp_addr); end
  endtask

  task automatic test_reset_mid();
    int cnt, side_err;
    logic [7:0] eb;
    sel = 0;
    eb  = exp_q[1];
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    cnt = 1;
    while (tx !== 1'b0 && cnt < 60) begin @(negedge clk); cnt++; end
    // middle of d3 of the second byte
    for (int i = 0; i < 10*BD + 4*BD + 3; i++) @(negedge clk);
    total++; if (tx !== eb[3]) begin bad++; $display("FAIL rst_mid line_before got %b want %b", tx, eb[3]); end
    rst = 1'b1;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_mid tx got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy got %b want 0", busy); end
    total++; if (addr !== 18'h3FFFE) begin bad++; $display("FAIL rst_mid addr got %h want 3fffe", addr); end
    @(negedge clk);
    rst = 1'b0;
    side_err = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) side_err++;
    end
    total++; if (side_err != 0) begin bad++; $display("FAIL rst_mid quiet_after got %0d want 0", side_err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    load_words(1, 16'hA55A, 16'h0000, 16'h0000);
    run_stream(1, -1, 1, 18'h00010, "single");
    load_words(3, 16'h0102, 16'h0304, 16'h0506);
    run_stream(0, -1, 0, 18'h00000, "wrap3");
    run_stream(0, 150, 0, 18'h00000, "start_busy");
    test_reset_mid();
    run_stream(0, -1, 0, 18'h00000, "after_rst");
    load_words(1, 16'hA55A, 16'h0000, 16'h0000);
    run_stream(1, -1, 2, 18'h00010, "b2b");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
